// File: rtl/lazy_seq_emit_ctrl.sv
// Lazy-match sequence emit controller: owns the job head pointer,
// buffers summary results as sequences and streams them downstream.
module lazy_seq_emit_ctrl #(
   parameter int JOB_LEN_LOG2    = 16,
   parameter int SEQ_LL_BITS     = 17,
   parameter int SEQ_ML_BITS     = 16,
   parameter int SEQ_OFFSET_BITS = 24,
   parameter int FIFO_DEPTH      = 8
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       i_job_start,
   input  logic                       i_issue,
   output logic                       o_can_issue,
   output logic [JOB_LEN_LOG2-1:0]    o_seq_head_ptr,
   input  logic                       i_summary_done,
   input  logic [SEQ_LL_BITS-1:0]     i_summary_ll,
   input  logic [SEQ_ML_BITS-1:0]     i_summary_ml,
   input  logic [SEQ_OFFSET_BITS-1:0] i_summary_offset,
   input  logic                       i_summary_eoj,
   input  logic [SEQ_ML_BITS-1:0]     i_summary_overlap_len,
   input  logic                       i_move_to_next_job,
   input  logic [JOB_LEN_LOG2-1:0]    i_move_forward,
   output logic                       o_seq_valid,
   input  logic                       i_seq_ready,
   output logic [SEQ_LL_BITS-1:0]     o_seq_ll,
   output logic [SEQ_ML_BITS-1:0]     o_seq_ml,
   output logic [SEQ_OFFSET_BITS-1:0] o_seq_offset,
   output logic                       o_seq_eoj,
   output logic                       o_job_done,
   output logic                       o_protocol_err,
   output logic                       o_overflow_err
);

   localparam int CW = $clog2(FIFO_DEPTH);
   localparam logic [CW:0]   DEPTH_C = (CW+1)'(FIFO_DEPTH);
   localparam logic [CW:0]   CNT_ONE = (CW+1)'(1);
   localparam logic [CW-1:0] PTR_ONE = CW'(1);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_RUN   = 2'd1;
   localparam logic [1:0] S_DRAIN = 2'd2;

   typedef struct packed {
      logic [SEQ_LL_BITS-1:0]     ll;
      logic [SEQ_ML_BITS-1:0]     ml;
      logic [SEQ_OFFSET_BITS-1:0] offset;
      logic                       eoj;
   } seq_t;

   logic [1:0]              state;
   logic                    in_flight;
   logic [JOB_LEN_LOG2-1:0] head_ptr;
   logic [JOB_LEN_LOG2-1:0] carry_ptr;

   seq_t                    mem [FIFO_DEPTH];
   logic [CW-1:0]           wr_ptr;
   logic [CW-1:0]           rd_ptr;
   logic [CW:0]             count;

   logic in_idle;
   logic in_run;
   logic in_drain;
   logic fifo_full;
   logic pop;
   logic sum_ok;
   logic push;
   logic overflow;
   logic proto_err;
   seq_t new_seq;

   always_comb begin
      in_idle   = (state == S_IDLE);
      in_run    = (state == S_RUN);
      in_drain  = (state == S_DRAIN);
      fifo_full = (count == DEPTH_C);
      pop       = o_seq_valid && i_seq_ready;
      sum_ok    = in_run && i_summary_done && in_flight;
      // A full FIFO can still take a push when the head leaves this cycle.
      push      = sum_ok && (!fifo_full || pop);
      overflow  = sum_ok && fifo_full && !pop;
      proto_err = (in_idle && (i_summary_done || i_issue))
               || (in_drain && (i_summary_done || i_issue))
               || (!in_idle && i_job_start)
               || (in_run && i_issue && !o_can_issue)
               || (in_run && i_summary_done && !in_flight)
               || (sum_ok && (i_summary_eoj != i_move_to_next_job));
   end

   always_comb begin
      new_seq.ll     = i_summary_ll;
      new_seq.ml     = i_summary_ml;
      new_seq.offset = i_summary_offset;
      new_seq.eoj    = i_summary_eoj;
   end

   assign o_can_issue    = in_run && !in_flight && (count < DEPTH_C);
   assign o_seq_head_ptr = head_ptr;
   assign o_seq_valid    = (count != '0);
   assign o_job_done     = in_drain && (count == '0);
   assign o_seq_ll       = mem[rd_ptr].ll;
   assign o_seq_ml       = mem[rd_ptr].ml;
   assign o_seq_offset   = mem[rd_ptr].offset;
   assign o_seq_eoj      = mem[rd_ptr].eoj;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= S_IDLE;
         head_ptr  <= '0;
         carry_ptr <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (i_job_start) begin
                  head_ptr  <= carry_ptr;
                  carry_ptr <= '0;
                  state     <= S_RUN;
               end
            end
            S_RUN: begin
               if (sum_ok) begin
                  if (i_move_to_next_job) begin
                     carry_ptr <= i_summary_overlap_len[JOB_LEN_LOG2-1:0];
                     state     <= S_DRAIN;
                  end else begin
                     head_ptr <= head_ptr + i_move_forward;
                  end
               end
            end
            S_DRAIN: begin
               if (o_job_done) state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   // An issue in the same cycle as a summary wins, so in_flight stays set.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         in_flight <= 1'b0;
      end else if (in_idle) begin
         in_flight <= 1'b0;
      end else if (in_run && i_issue) begin
         in_flight <= 1'b1;
      end else if (sum_ok) begin
         in_flight <= 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            mem[wr_ptr] <= new_seq;
            wr_ptr      <= wr_ptr + PTR_ONE;
         end
         if (pop) rd_ptr <= rd_ptr + PTR_ONE;
         case ({push, pop})
            2'b10:   count <= count + CNT_ONE;
            2'b01:   count <= count - CNT_ONE;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         o_protocol_err <= 1'b0;
         o_overflow_err <= 1'b0;
      end else begin
         if (proto_err) o_protocol_err <= 1'b1;
         if (overflow)  o_overflow_err <= 1'b1;
      end
   end

endmodule

// File: doc/lazy_seq_emit_ctrl.md
Name: lazy_seq_emit_ctrl

Overview:
- Sits directly downstream of the lazy-match summary pipeline and consumes its per-match summary results.
- Owns the per-job sequence head pointer and feeds it back to the match issue logic. Only one match may be in flight at a time.
- Buffers the resulting sequences (literal length, match length, offset, end-of-job) in a small FIFO and emits them to the sequence encoder over a valid/ready stream.
- Sequences job start and job completion, carrying any cross-job match overlap into the next job's head pointer.

Parameters:
JOB_LEN_LOG2, 16, job length log2; the head pointer width.
SEQ_LL_BITS, 17, sequence literal-length width.
SEQ_ML_BITS, 16, sequence match-length and overlap width.
SEQ_OFFSET_BITS, 24, sequence offset width.
FIFO_DEPTH, 8, sequence FIFO entries; a power of 2, at least 2.

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
i_job_start  in  1  pulse: start a new job (legal only in IDLE)
i_issue  in  1  pulse: upstream launched one match using o_seq_head_ptr
o_can_issue  out  1  upstream may assert i_issue this cycle
o_seq_head_ptr  out  JOB_LEN_LOG2  current sequence head pointer within the job
i_summary_done  in  1  summary result valid (one-cycle pulse)
i_summary_ll  in  SEQ_LL_BITS  summary literal length
i_summary_ml  in  SEQ_ML_BITS  summary match length (0 means literal-only)
i_summary_offset  in  SEQ_OFFSET_BITS  summary match offset
i_summary_eoj  in  1  last sequence of the job
i_summary_overlap_len  in  SEQ_ML_BITS  bytes the match extends into the next job
i_move_to_next_job  in  1  job finished by this summary
i_move_forward  in  JOB_LEN_LOG2  head advance when not finishing the job
o_seq_valid  out  1  sequence available
i_seq_ready  in  1  downstream accepts the sequence
o_seq_ll  out  SEQ_LL_BITS  sequence literal length
o_seq_ml  out  SEQ_ML_BITS  sequence match length
o_seq_offset  out  SEQ_OFFSET_BITS  sequence offset
o_seq_eoj  out  1  end-of-job marker
o_job_done  out  1  one-cycle pulse: job fully drained
o_protocol_err  out  1  sticky: illegal i_issue, i_job_start or summary
o_overflow_err  out  1  sticky: push into a full FIFO was dropped

Behaviour:
- Clock and reset: all state is on clk with asynchronous active-high rst.
- Reset values:
  - state=IDLE, in_flight=0, FIFO empty, head_ptr=0, carry_ptr=0.
  - All outputs 0: o_can_issue, o_seq_valid, o_job_done, both error flags, all data outputs.
  - Reset asserted mid-job discards the FIFO contents and any in-flight match.
- State IDLE:
  - i_job_start loads head_ptr<=carry_ptr, clears carry_ptr, and goes to RUN.
  - A summary or i_issue received in IDLE sets o_protocol_err; the summary is dropped.
- State RUN:
  - o_can_issue = (in_flight==0) && (fifo_count < FIFO_DEPTH). It is combinational from registered state.
  - i_issue sets in_flight=1. i_issue while o_can_issue==0 sets o_protocol_err; in_flight stays 1.
  - i_summary_done with in_flight==0 sets o_protocol_err and is dropped (no push, no pointer update).
- Legal summary in RUN: push {ll, ml, offset, eoj} into the FIFO and clear in_flight.
  - If i_move_to_next_job: carry_ptr<=i_summary_overlap_len[JOB_LEN_LOG2-1:0], head_ptr unchanged, go to DRAIN.
  - Otherwise: head_ptr<=head_ptr+i_move_forward, modulo 2^JOB_LEN_LOG2.
  - The upstream guarantees head_ptr+i_move_forward < 2^JOB_LEN_LOG2 and overlap < 2^JOB_LEN_LOG2; these are not checked.
- Consistency check: i_summary_eoj without i_move_to_next_job, or the reverse, sets o_protocol_err; the summary is still processed using i_move_to_next_job.
- State DRAIN:
  - o_can_issue=0.
  - When the FIFO is empty, drive o_job_done=1 for one cycle and go to IDLE on the same edge.
  - Summary or i_issue received in DRAIN sets o_protocol_err and is dropped.
  - i_job_start received in RUN or DRAIN sets o_protocol_err and is ignored.
- Timing:
  - A summary at edge t is visible at the FIFO head no earlier than t+1: o_seq_valid rises the cycle after the push when the FIFO was empty.
  - The head_ptr update and o_can_issue re-assertion are also visible at t+1.
  - The FIFO is first-word-fall-through with registered outputs. o_seq_* hold stable while o_seq_valid && !i_seq_ready.
- FIFO boundary behaviour:
  - Pop when o_seq_valid && i_seq_ready.
  - Simultaneous push and pop when full is legal, and the count is unchanged.
  - Push when full with no pop sets o_overflow_err and drops the entry. It is unreachable if the o_can_issue rule is obeyed.
  - The FIFO pointers wrap modulo FIFO_DEPTH.
- Error flags: both are sticky until rst.

Test Plan:
- Head pointer advance: rst, job_start, issue, then summary{ll=3, ml=5, offset=100, move_forward=8} -> head_ptr 0->8 and o_can_issue=1 at t+1. Next cycle o_seq ll=3, ml=5, off=100, eoj=0.
- Job end and drain: summary{eoj=1, move_to_next_job=1, overlap=4} with ready=1 -> entered DRAIN, o_job_done pulses exactly 1 cycle after eoj sequence popped, state IDLE. Next job_start -> head_ptr=4.
- Backpressure: i_seq_ready=0 for FIFO_DEPTH(=8) summaries -> o_can_issue=0 once count=8, data stable. Raise ready -> 8 sequences drained in order, no overflow_err.
- Protocol errors: i_issue while in_flight=1, and a summary arriving in IDLE -> o_protocol_err=1 and stays 1. FIFO count and head_ptr are unchanged by the dropped summary.
- Wrap-around: head_ptr=65530, move_forward=6 -> head_ptr=0; FIFO pointers wrap after 20 push/pop pairs with data intact.
- Reset mid-job: rst asserted with 3 queued sequences in RUN -> o_seq_valid=0 immediately (async), all state reset, carry_ptr=0.
